cache_controller: RTL and testbench

//   Sequencing FSM for one direct-mapped data-cache bank (8 sets x 128-bit lines, 25-bit tag).

---
 rtl/cache_controller_pkg.sv | 25 ++
 rtl/cache_controller_stat_counter.sv | 31 +++
 rtl/cache_controller.sv | 187 ++++++++++++++++++
 tb/tb_cache_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared constants, state encodings and address helpers for the direct-mapped
// data-cache bank controller.
package cache_controller_pkg;

   localparam int ADDR_W = 32;
   localparam int WORD_W = 32;
   localparam int LINE_W = 128;
   localparam int TAG_W  = 25;
   localparam int IDX_W  = 3;
   localparam int OFF_W  = 4;

   typedef enum logic [2:0] {
      CACHE_IDLE       = 3'd0,
      CACHE_COMPARE    = 3'd1,
      CACHE_WRITE_BACK = 3'd2,
      CACHE_ALLOCATE   = 3'd3,
      CACHE_FILL       = 3'd4
   } cache_state_e;

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_controller_stat_counter.sv
// 32-bit event counter with increment and synchronous clear; wraps at 2^32.
module cache_stat_counter
(
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] count
);

   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc)
         count_d = count_q + 32'd1;
   end

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for one direct-mapped data-cache bank: lookup, dirty write-back,
// allocate, fill and re-lookup, plus pipeline stall and hit/miss statistics.
module cache_controller
   import cache_controller_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              is_stall,
   output logic [ADDR_W-1:0] bank_addr,
   output logic              bank_lookup,
   input  logic              bank_hit,
   input  logic              bank_dirty,
   input  logic [TAG_W-1:0]  bank_victim_tag,
   input  logic [LINE_W-1:0] bank_victim_line,
   input  logic [WORD_W-1:0] bank_rword,
   output logic              bank_word_write,
   output logic [WORD_W-1:0] bank_wdata,
   output logic              bank_fill,
   output logic [LINE_W-1:0] bank_fill_line,
   output logic              mem_req_valid,
   output logic              mem_req_write,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_wline,
   input  logic              mem_done,
   input  logic [LINE_W-1:0] mem_rline,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   cache_state_e      state_q, state_d;
   logic              req_rw_q, req_rw_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [WORD_W-1:0] req_wdata_q, req_wdata_d;
   logic [LINE_W-1:0] victim_line_q, victim_line_d;
   logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
   logic [LINE_W-1:0] fill_line_q, fill_line_d;
   logic              first_lookup_q, first_lookup_d;
   logic              hit_inc, miss_inc;

   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;

   assign req_idx = req_addr_q[OFF_W +: IDX_W];
   assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d         = state_q;
      req_rw_d        = req_rw_q;
      req_addr_d      = req_addr_q;
      req_wdata_d     = req_wdata_q;
      victim_line_d   = victim_line_q;
      victim_addr_d   = victim_addr_q;
      fill_line_d     = fill_line_q;
      first_lookup_d  = first_lookup_q;
      hit_inc         = 1'b0;
      miss_inc        = 1'b0;

      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = '0;
      is_stall        = 1'b0;
      bank_addr       = req_addr_q;
      bank_lookup     = 1'b0;
      bank_word_write = 1'b0;
      bank_wdata      = '0;
      bank_fill       = 1'b0;
      bank_fill_line  = '0;
      mem_req_valid   = 1'b0;
      mem_req_write   = 1'b0;
      mem_req_addr    = '0;
      mem_wline       = '0;

      case (state_q)
         CACHE_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               req_rw_d       = req_rw;
               req_addr_d     = req_addr;
               req_wdata_d    = req_wdata;
               first_lookup_d = 1'b1;
               is_stall       = 1'b1;
               state_d        = CACHE_COMPARE;
            end
         end

         CACHE_COMPARE: begin
            bank_lookup = 1'b1;
            if (bank_hit) begin
               resp_valid = 1'b1;
               if (req_rw_q) begin
                  bank_word_write = 1'b1;
                  bank_wdata      = req_wdata_q;
               end else begin
                  resp_rdata = bank_rword;
               end
               // The post-fill re-lookup always hits; only the original lookup counts.
               hit_inc = first_lookup_q;
               state_d = CACHE_IDLE;
            end else begin
               is_stall      = 1'b1;
               miss_inc      = 1'b1;
               victim_line_d = bank_victim_line;
               victim_addr_d = line_addr(bank_victim_tag, req_idx);
               state_d       = bank_dirty ? CACHE_WRITE_BACK : CACHE_ALLOCATE;
            end
         end

         CACHE_WRITE_BACK: begin
            is_stall      = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = victim_addr_q;
            mem_wline     = victim_line_q;
            if (mem_done)
               state_d = CACHE_ALLOCATE;
         end

         CACHE_ALLOCATE: begin
            is_stall      = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_addr  = line_addr(req_tag, req_idx);
            if (mem_done) begin
               fill_line_d = mem_rline;
               state_d     = CACHE_FILL;
            end
         end

         CACHE_FILL: begin
            is_stall       = 1'b1;
            bank_fill      = 1'b1;
            bank_fill_line = fill_line_q;
            first_lookup_d = 1'b0;
            state_d        = CACHE_COMPARE;
         end

         default: state_d = CACHE_IDLE;
      endcase
   end

   // NOTE: datapath buffers are reset too, keeping every bank/memory output at zero out of reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= CACHE_IDLE;
         req_rw_q       <= 1'b0;
         req_addr_q     <= '0;
         req_wdata_q    <= '0;
         victim_line_q  <= '0;
         victim_addr_q  <= '0;
         fill_line_q    <= '0;
         first_lookup_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         req_rw_q       <= req_rw_d;
         req_addr_q     <= req_addr_d;
         req_wdata_q    <= req_wdata_d;
         victim_line_q  <= victim_line_d;
         victim_addr_q  <= victim_addr_d;
         fill_line_q    <= fill_line_d;
         first_lookup_q <= first_lookup_d;
      end
   end

   cache_stat_counter u_hit_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (hit_inc),
      .clr   (1'b0),
      .count (hit_count)
   );

   cache_stat_counter u_miss_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (miss_inc),
      .clr   (1'b0),
      .count (miss_count)
   );

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural bank and memory around the DUT, with a
// request-level golden model predicting hit/miss, write-backs, data and latency.
module tb_cache_controller;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [127:0] line;
   } mem_txn_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_rw = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_wdata = '0;
   logic         req_ready, resp_valid, is_stall, bank_lookup;
   logic [31:0]  resp_rdata, bank_addr, bank_wdata, mem_req_addr;
   logic         bank_hit, bank_dirty, bank_word_write, bank_fill;
   logic [24:0]  bank_victim_tag;
   logic [127:0] bank_victim_line, bank_fill_line, mem_wline;
   logic [31:0]  bank_rword;
   logic         mem_req_valid, mem_req_write;
   logic         mem_done = 1'b0;
   logic [127:0] mem_rline = '0;
   logic [31:0]  hit_count, miss_count;

   int checks = 0;
   int errors = 0;

   cache_controller dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_rw           (req_rw),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_ready        (req_ready),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .is_stall         (is_stall),
      .bank_addr        (bank_addr),
      .bank_lookup      (bank_lookup),
      .bank_hit         (bank_hit),
      .bank_dirty       (bank_dirty),
      .bank_victim_tag  (bank_victim_tag),
      .bank_victim_line (bank_victim_line),
      .bank_rword       (bank_rword),
      .bank_word_write  (bank_word_write),
      .bank_wdata       (bank_wdata),
      .bank_fill        (bank_fill),
      .bank_fill_line   (bank_fill_line),
      .mem_req_valid    (mem_req_valid),
      .mem_req_write    (mem_req_write),
      .mem_req_addr     (mem_req_addr),
      .mem_wline        (mem_wline),
      .mem_done         (mem_done),
      .mem_rline        (mem_rline),
      .hit_count        (hit_count),
      .miss_count       (miss_count)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural cache bank ----------------
   logic [7:0]   b_valid = '0;
   logic [7:0]   b_dirty = '0;
   logic [24:0]  b_tag  [8];
   logic [127:0] b_data [8];
   logic [2:0]   b_idx;
   logic [1:0]   b_word;

   assign b_idx            = bank_addr[6:4];
   assign b_word           = bank_addr[3:2];
   assign bank_hit         = b_valid[b_idx] && (b_tag[b_idx] == bank_addr[31:7]);
   assign bank_dirty       = b_valid[b_idx] && b_dirty[b_idx];
   assign bank_victim_tag  = b_tag[b_idx];
   assign bank_victim_line = b_data[b_idx];
   assign bank_rword       = b_data[b_idx][32*b_word +: 32];

   always @(posedge clk) begin
      if (bank_fill) begin
         b_valid[b_idx] <= 1'b1;
         b_dirty[b_idx] <= 1'b0;
         b_tag[b_idx]   <= bank_addr[31:7];
         b_data[b_idx]  <= bank_fill_line;
      end
      if (bank_word_write) begin
         b_data[b_idx][32*b_word +: 32] <= bank_wdata;
         b_dirty[b_idx]                 <= 1'b1;
      end
   end

   // ---------------- behavioural line memory ----------------
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   logic [127:0] mem_lines [logic [31:0]];

   function automatic logic [127:0] mem_rd(input logic [31:0] la);
      logic [127:0] l;
      if (mem_lines.exists(la)) return mem_lines[la];
      for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word(la + 32'(4*i));
      return l;
   endfunction

   int           mem_lat = 1;
   int           mcnt = 0;
   bit           spurious = 1'b0;
   int           unstable = 0;
   mem_txn_t     mem_log[$];
   logic         s_wr;
   logic [31:0]  s_addr;
   logic [127:0] s_wline;

   always @(negedge clk) begin
      mem_done = 1'b0;
      if (spurious) begin
         mem_done  = 1'b1;
         mem_rline = {$urandom, $urandom, $urandom, $urandom};
      end else if (!reset || !mem_req_valid) begin
         mcnt = 0;
      end else begin
         mcnt++;
         if (mcnt == 1) begin
            s_wr = mem_req_write; s_addr = mem_req_addr; s_wline = mem_wline;
         end else if (mem_req_write !== s_wr || mem_req_addr !== s_addr || mem_wline !== s_wline) begin
            unstable++;
         end
         if (mcnt >= mem_lat) begin
            if (mem_req_write) begin
               mem_lines[mem_req_addr] = mem_wline;
               mem_log.push_back('{1'b1, mem_req_addr, mem_wline});
            end else begin
               mem_rline = mem_rd(mem_req_addr);
               mem_log.push_back('{1'b0, mem_req_addr, mem_rline});
            end
            mem_done = 1'b1;
            mcnt     = 0;
         end
      end
   end

   // ---------------- request-level golden model ----------------
   logic [31:0] gold [logic [31:0]];
   logic [7:0]  ref_valid = '0;
   logic [7:0]  ref_dirty = '0;
   logic [24:0] ref_tag [8];
   int          ref_hits = 0;
   int          ref_misses = 0;

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : init_word(a);
   endfunction

   function automatic logic [127:0] gold_line(input logic [31:0] la);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[32*i +: 32] = gold_rd(la + 32'(4*i));
      return l;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit noise);
      logic [2:0]   idx;
      logic [24:0]  tag;
      logic [31:0]  va, la, rdata, rnd;
      logic [127:0] vline;
      bit           exp_hit, exp_wb, got;
      logic         stall_at_resp;
      int           exp_lat, exp_n, cyc, n0, u0, stall_lows;

      idx     = addr[6:4];
      tag     = addr[31:7];
      la      = {addr[31:4], 4'h0};
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
      exp_wb  = !exp_hit && ref_valid[idx] && ref_dirty[idx];
      va      = {ref_tag[idx], idx, 4'h0};
      vline   = gold_line(va);
      exp_lat = exp_hit ? 1 : (exp_wb ? 3 + 2*mem_lat : 3 + mem_lat);
      exp_n   = exp_hit ? 0 : (exp_wb ? 2 : 1);
      n0      = mem_log.size();
      u0      = unstable;

      step();
      req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
      #1;
      chk("req_ready_at_accept", req_ready, 1'b1);
      chk("stall_at_accept", is_stall, 1'b1);

      got = 1'b0; cyc = 0; stall_lows = 0; rdata = '0; stall_at_resp = 1'bx;
      while (!got && cyc < 400) begin
         step();
         cyc++;
         if (noise) begin
            rnd = $urandom;
            req_rw = rnd[0]; req_addr = $urandom; req_wdata = $urandom;
         end else begin
            req_valid = 1'b0;
         end
         if (resp_valid) begin
            got = 1'b1; rdata = resp_rdata; stall_at_resp = is_stall; req_valid = 1'b0;
         end else if (!is_stall) begin
            stall_lows++;
         end
      end
      req_valid = 1'b0;

      chk("resp_seen", got, 1'b1);
      chk("latency", cyc, exp_lat);
      if (!rw) chk("load_data", rdata, gold_rd(addr));
      chk("stall_low_on_resp", stall_at_resp, 1'b0);
      chk("stall_gaps", stall_lows, 0);

      if (exp_hit) ref_hits++;
      else begin
         ref_misses++;
         ref_valid[idx] = 1'b1; ref_dirty[idx] = 1'b0; ref_tag[idx] = tag;
      end
      if (rw) begin
         gold[addr] = wdata;
         ref_dirty[idx] = 1'b1;
      end

      step();
      chk("hit_count", hit_count, 32'(ref_hits));
      chk("miss_count", miss_count, 32'(ref_misses));
      chk("idle_after_resp", req_ready, 1'b1);
      chk("mem_txn_count", mem_log.size() - n0, exp_n);
      if (mem_log.size() - n0 == exp_n && exp_n > 0) begin
         if (exp_wb) begin
            chk("wb_is_write", mem_log[n0].wr, 1'b1);
            chk("wb_addr", mem_log[n0].addr, va);
            chk("wb_line", mem_log[n0].line, vline);
         end
         chk("rd_is_read", mem_log[n0+exp_n-1].wr, 1'b0);
         chk("rd_addr", mem_log[n0+exp_n-1].addr, la);
      end
      chk("mem_req_stable", unstable - u0, 0);
   endtask

   logic [24:0] tag_pool [4];

   initial begin
      int bound;
      bit seen;
      logic [31:0] r;
      tag_pool[0] = 25'h0; tag_pool[1] = 25'h1; tag_pool[2] = 25'h8; tag_pool[3] = 25'h1ABCD;

      // Reset state
      #3 reset = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_is_stall", is_stall, 1'b0);
      chk("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_bank_lookup", bank_lookup, 1'b0);
      chk("rst_bank_fill", bank_fill, 1'b0);
      chk("rst_mem_req_addr", mem_req_addr, 32'h0);
      chk("rst_hit_count", hit_count, 32'h0);
      chk("rst_miss_count", miss_count, 32'h0);
      step(); step();
      reset = 1'b1;
      step();

      // Cold load miss, then the repeat load hits in one cycle
      mem_lat = 2;
      do_req(1'b0, 32'h40, 32'h0, 1'b0);
      do_req(1'b0, 32'h40, 32'h0, 1'b0);

      // Store miss with merge after fill, then load it back without memory traffic
      do_req(1'b1, 32'h1044, 32'hCAFE_F00D, 1'b0);
      do_req(1'b1, 32'h44, 32'hDEAD_BEEF, 1'b0);
      do_req(1'b0, 32'h44, 32'h0, 1'b0);

      // Dirty eviction of line 0x40 by 0x444
      mem_lat = 1;
      do_req(1'b0, 32'h444, 32'h0, 1'b0);

      // Spurious mem_done while idle
      @(posedge clk); #1 spurious = 1'b1;
      @(posedge clk); #1 spurious = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("spur_idle", req_ready, 1'b1);
         chk("spur_no_fill", bank_fill, 1'b0);
         chk("spur_no_mem", mem_req_valid, 1'b0);
         chk("spur_no_resp", resp_valid, 1'b0);
      end
      do_req(1'b0, 32'h444, 32'h0, 1'b0);

      // Slow memory with requests held high throughout
      mem_lat = 20;
      do_req(1'b0, 32'h1230, 32'h0, 1'b1);
      do_req(1'b1, 32'h2444, 32'h1357_9BDF, 1'b1);

      // Reset during a write-back
      do_req(1'b1, 32'h80, 32'h1122_3344, 1'b0);
      step();
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h880;
      step();
      req_valid = 1'b0;
      seen = 1'b0; bound = 0;
      while (!seen && bound < 40) begin
         step(); bound++;
         seen = mem_req_valid && mem_req_write;
      end
      chk("wb_started", seen, 1'b1);
      step(); step(); step();
      reset = 1'b0;
      #1;
      chk("rst_wb_mem_req_valid", mem_req_valid, 1'b0);
      chk("rst_wb_req_ready", req_ready, 1'b1);
      chk("rst_wb_is_stall", is_stall, 1'b0);
      chk("rst_wb_hit_count", hit_count, 32'h0);
      chk("rst_wb_miss_count", miss_count, 32'h0);
      step();
      reset = 1'b1;
      ref_hits = 0; ref_misses = 0;
      step();
      chk("post_rst_idle", req_ready, 1'b1);
      chk("post_rst_no_mem", mem_req_valid, 1'b0);

      // Randomized traffic over a small tag pool so hits, clean and dirty misses mix
      for (int n = 0; n < 60; n++) begin
         r = $urandom;
         mem_lat = $urandom_range(4, 1);
         do_req(r[0], {tag_pool[r[2:1]], r[5:3], r[7:6], 2'b00}, $urandom, (n % 10) == 9);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
